// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
//
// Signals:
//   start      - conversion request, only looked at while the converter is idle
//   bcd_in     - 10-digit packed BCD, digit 9 in [39:36] down to digit 0 in [3:0]
//   busy       - high while a conversion is in progress
//   done       - single-cycle pulse marking a valid result
//   binary_out - 32-bit result, held until the next conversion finishes
//   overflow   - decimal value did not fit in 32 bits (result saturated)
//   invalid    - some input nibble was greater than 9 (result forced to 0)
//
// Modports:
//   master - requester side (drives start/bcd_in)
//   slave  - converter side (drives busy/done/results)
interface bcd_to_binary_seq_if;
  logic        start;
  logic [39:0] bcd_in;
  logic        busy;
  logic        done;
  logic [31:0] binary_out;
  logic        overflow;
  logic        invalid;

  modport master (
    output start, bcd_in,
    input  busy, done, binary_out, overflow, invalid
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, binary_out, overflow, invalid
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble.
//
// A 10-digit packed BCD number is shifted right one bit per clock into a
// 34-bit binary accumulator; after every shift each BCD digit that reads 8
// or more is reduced by 3. 34 iterations are enough for 9999999999 (< 2^34).
// Values above 32'hFFFFFFFF saturate and raise overflow; any nibble above 9
// skips the shifting, forces the result to 0 and raises invalid.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears all state and outputs
//   bus   - bcd_to_binary_seq_if.slave (start, bcd_in, busy, done,
//           binary_out, overflow, invalid)
//
// Timing: start accepted at edge N -> done high in the cycle after edge N+35
// (after edge N+1 for invalid input); busy high after edges N..N+34.
module bcd_to_binary_seq (
  input  logic               clk,
  input  logic               rst_n,
  bcd_to_binary_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd33;

  state_t      state_reg, state_next;
  logic [39:0] r_bcd_reg, r_bcd_next;
  logic [33:0] r_bin_reg, r_bin_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [31:0] binary_out_reg, binary_out_next;
  logic        overflow_reg, overflow_next;
  logic        invalid_reg, invalid_next;

  // BCD part after the right shift, and after the per-digit correction.
  logic [39:0] s_bcd;
  logic [39:0] c_bcd;
  // Per-digit "nibble > 9" flags on the incoming request.
  logic [9:0]  nib_bad;

  // The BCD field's LSB moves into the top of the binary accumulator.
  assign s_bcd = {1'b0, r_bcd_reg[39:1]};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_digit
      // A shifted digit of 8 or more carries a borrowed 10 worth 8 at this
      // weight; subtracting 3 restores a valid BCD digit for the next shift.
      assign c_bcd[gi*4 +: 4] = s_bcd[gi*4 + 3] ? (s_bcd[gi*4 +: 4] - 4'd3)
                                                 : s_bcd[gi*4 +: 4];
      assign nib_bad[gi] = (bus.bcd_in[gi*4 +: 4] > 4'd9);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      r_bcd_reg      <= '0;
      r_bin_reg      <= '0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      binary_out_reg <= '0;
      overflow_reg   <= 1'b0;
      invalid_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      r_bcd_reg      <= r_bcd_next;
      r_bin_reg      <= r_bin_next;
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      binary_out_reg <= binary_out_next;
      overflow_reg   <= overflow_next;
      invalid_reg    <= invalid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    r_bcd_next      = r_bcd_reg;
    r_bin_next      = r_bin_reg;
    cnt_next        = cnt_reg;
    err_next        = err_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    binary_out_next = binary_out_reg;
    overflow_next   = overflow_reg;
    invalid_next    = invalid_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          r_bcd_next = bus.bcd_in;
          r_bin_next = '0;
          cnt_next   = '0;
          err_next   = |nib_bad;
          busy_next  = 1'b1;
          state_next = (|nib_bad) ? FINISH : SHIFT;
        end
      end

      SHIFT: begin
        r_bcd_next = c_bcd;
        r_bin_next = {r_bcd_reg[0], r_bin_reg[33:1]};
        cnt_next   = cnt_reg + 6'd1;
        if (cnt_reg == LAST_ITER) begin
          state_next = FINISH;
        end
      end

      FINISH: begin
        invalid_next  = err_reg;
        overflow_next = !err_reg && (|r_bin_reg[33:32]);
        if (err_reg) begin
          binary_out_next = '0;
        end else if (|r_bin_reg[33:32]) begin
          binary_out_next = 32'hFFFF_FFFF;
        end else begin
          binary_out_next = r_bin_reg[31:0];
        end
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.binary_out = binary_out_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.invalid    = invalid_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq. Expected results come
// from a decimal reference model and are queued when a request is driven;
// a monitor pops and compares them whenever done is seen.
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_to_binary_seq_if bus_if ();

  bcd_to_binary_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [39:0] bcd;
    logic [31:0] bin;
    logic        ovf;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic done_prev = 1'b0;

  logic [39:0] b2b_vals [3] = '{40'h0000000001, 40'h0000001000, 40'h0000000042};

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decode the digits as a decimal number.
  function automatic exp_t model(input logic [39:0] b);
    exp_t            e;
    longint unsigned v;
    logic [3:0]      nib;
    bit              inv;
    v   = 0;
    inv = 0;
    for (int i = 9; i >= 0; i--) begin
      nib = b[i*4 +: 4];
      if (nib > 4'd9) inv = 1;
      v = v * 10 + 64'(nib);
    end
    e.bcd = b;
    if (inv) begin
      e.bin = '0; e.ovf = 1'b0; e.inv = 1'b1;
    end else if (v > 64'hFFFF_FFFF) begin
      e.bin = 32'hFFFF_FFFF; e.ovf = 1'b1; e.inv = 1'b0;
    end else begin
      e.bin = v[31:0]; e.ovf = 1'b0; e.inv = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done_prev === 1'b1) check("done_single_cycle", {39'd0, bus_if.done}, 40'd0);
    if (bus_if.done === 1'b1) begin
      check("done_expected", {39'd0, sb.size() != 0}, 40'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("binary_out", {8'd0, bus_if.binary_out}, {8'd0, e.bin});
        check("overflow", {39'd0, bus_if.overflow}, {39'd0, e.ovf});
        check("invalid", {39'd0, bus_if.invalid}, {39'd0, e.inv});
        if (!e.inv) check("r_bcd_drained", dut.r_bcd_reg, 40'd0);
        $display("xact bcd=%010h bin=%08h ovf=%0b inv=%0b (exp bin=%08h ovf=%0b inv=%0b)",
                 e.bcd, bus_if.binary_out, bus_if.overflow, bus_if.invalid,
                 e.bin, e.ovf, e.inv);
      end
    end
    done_prev <= bus_if.done;
  end

  // One request; waits for done, checking latency and busy duration.
  // pulse_at >= 0 drives a second start with pulse_bcd that many cycles in.
  task automatic convert(input logic [39:0] bcd, input int exp_lat, input int pulse_at,
                         input logic [39:0] pulse_bcd, input string tag);
    int          lat;
    int          busy_cnt;
    logic [63:0] junk;
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.bcd_in = bcd;
    sb.push_back(model(bcd));
    @(negedge clk);
    bus_if.start  = 1'b0;
    junk          = {$urandom, $urandom};
    bus_if.bcd_in = junk[39:0];
    lat      = 0;
    busy_cnt = 0;
    while (bus_if.done !== 1'b1 && lat < 100) begin
      if (bus_if.busy === 1'b1) busy_cnt++;
      bus_if.start = (lat == pulse_at);
      if (lat == pulse_at) bus_if.bcd_in = pulse_bcd;
      @(negedge clk);
      lat++;
    end
    bus_if.start = 1'b0;
    check({tag, "_latency"}, 40'(lat), 40'(exp_lat));
    check({tag, "_busy_cycles"}, 40'(busy_cnt), 40'(exp_lat));
    check({tag, "_busy_low_at_done"}, {39'd0, bus_if.busy}, 40'd0);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {39'd0, bus_if.busy}, 40'd0);
    check("rst_done", {39'd0, bus_if.done}, 40'd0);
    check("rst_binary_out", {8'd0, bus_if.binary_out}, 40'd0);
    check("rst_overflow", {39'd0, bus_if.overflow}, 40'd0);
    check("rst_invalid", {39'd0, bus_if.invalid}, 40'd0);
    rst_n = 1'b1;

    convert(40'h0000000000, 35, -1, 40'd0, "zero");
    convert(40'h0000012345, 35, -1, 40'd0, "d12345");
    convert(40'h0000000255, 35, -1, 40'd0, "d255");
    convert(40'h4294967295, 35, -1, 40'd0, "max32");
    convert(40'h4294967296, 35, -1, 40'd0, "max32p1");
    convert(40'h9999999999, 35, -1, 40'd0, "max_bcd");
    convert(40'h00000000A1, 1, -1, 40'd0, "invalid");
    convert(40'h0000054321, 35, 10, 40'h0000000777, "ignore_start");

    // Start held high: back-to-back conversions every 36 cycles.
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.bcd_in = b2b_vals[0];
    sb.push_back(model(b2b_vals[0]));
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus_if.done !== 1'b1 && n < 100);
      check("b2b_interval", 40'(n), 40'd36);
      if (k < 2) begin
        bus_if.bcd_in = b2b_vals[k+1];
        sb.push_back(model(b2b_vals[k+1]));
      end else begin
        bus_if.start = 1'b0;
      end
    end

    // Abort a conversion with reset; no result may appear.
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.bcd_in = 40'h0000012345;
    @(negedge clk);
    bus_if.start  = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {39'd0, bus_if.busy}, 40'd0);
    check("abort_done", {39'd0, bus_if.done}, 40'd0);
    check("abort_binary_out", {8'd0, bus_if.binary_out}, 40'd0);
    check("abort_overflow", {39'd0, bus_if.overflow}, 40'd0);
    check("abort_invalid", {39'd0, bus_if.invalid}, 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_still_idle", {39'd0, bus_if.busy}, 40'd0);

    convert(40'h0000000100, 35, -1, 40'd0, "after_reset");
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 40'(sb.size()), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
